// File: rtl/store_enc.sv
// Store encoder: aligns, size/strobe/lane-encodes one MEM-stage store and drives
// it over an SRAM-like req/addr_ok/data_ok bus, rejecting misaligned stores as AdES.
module store_enc (
    input  logic        clk,
    input  logic        resetn,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        flush,
    output logic        st_ready,
    output logic        st_done,
    output logic        st_ades,
    output logic [31:0] st_badvaddr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_cancel, w_cancel_nxt;
    logic        w_done_nxt;
    logic        w_accept, w_misaligned, w_issue;
    logic [1:0]  w_size;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        r_done, r_ades;
    logic [31:0] r_badvaddr, r_addr, r_wdata;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;

    assign st_ready = (r_state == S_IDLE);
    assign w_accept = st_valid & st_ready & ~flush;
    assign w_issue  = w_accept & ~w_misaligned;

    always_comb begin
        w_misaligned = 1'b0;
        w_size       = 2'd2;
        w_wdata      = st_data;
        w_wstrb      = 4'b1111;
        case (st_op)
            2'b00: begin
                w_size  = 2'd0;
                w_wdata = {4{st_data[7:0]}};
                w_wstrb = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                w_misaligned = st_addr[0];
                w_size       = 2'd1;
                w_wdata      = {2{st_data[15:0]}};
                w_wstrb      = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: w_misaligned = |st_addr[1:0];
        endcase
    end

    // A flush while the bus owes us data_ok only marks the store cancelled;
    // the handshake must still drain so the bus protocol stays intact.
    always_comb begin
        w_state_nxt  = r_state;
        w_cancel_nxt = r_cancel;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cancel_nxt = 1'b0;
                if (w_issue) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    w_state_nxt  = S_WAIT;
                    w_cancel_nxt = flush;
                end else if (flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) w_cancel_nxt = 1'b1;
                if (data_data_ok) begin
                    w_state_nxt  = S_IDLE;
                    w_done_nxt   = ~(r_cancel | flush);
                    w_cancel_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cancel <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cancel <= w_cancel_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_done     <= 1'b0;
            r_ades     <= 1'b0;
            r_badvaddr <= '0;
            r_size     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
        end else begin
            r_done <= w_done_nxt;
            r_ades <= w_accept & w_misaligned;
            if (w_accept && w_misaligned) r_badvaddr <= st_addr;
            if (w_issue) begin
                r_size  <= w_size;
                r_addr  <= st_addr;
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
            end
        end
    end

    assign st_done     = r_done;
    assign st_ades     = r_ades;
    assign st_badvaddr = r_badvaddr;
    assign data_req    = (r_state == S_REQ);
    assign data_wr     = data_req;
    assign data_size   = r_size;
    assign data_addr   = r_addr;
    assign data_wdata  = r_wdata;
    assign data_wstrb  = r_wstrb;

endmodule

// File: doc/store_enc.md
# store_enc

Store-side counterpart of the load data decoder: accepts one store at a time from the MEM stage, checks alignment, encodes size, byte strobes and lane-replicated write data, and drives the store over the SRAM-like data bus with a req/addr_ok/data_ok handshake. It raises an address-error-on-store (AdES) instead of issuing misaligned stores, and absorbs pipeline flushes without corrupting the bus protocol. It sits between the MEM stage and the data-side bus bridge.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- st_valid  in  1  store request valid
- st_op  in  2  00 SB, 01 SH, 10 SW, 11 treated as SW
- st_addr  in  32  byte address
- st_data  in  32  store source register; low bits carry byte/half
- flush  in  1  cancel any in-flight store (exception/eret)
- st_ready  out  1  high only in IDLE; request accepted on st_valid & st_ready & ~flush
- st_done  out  1  one-cycle pulse: store written (data_ok seen, not cancelled)
- st_ades  out  1  one-cycle pulse: misaligned store rejected
- st_badvaddr  out  32  faulting address, valid with st_ades, held until next rejection
- data_req  out  1  bus request
- data_wr  out  1  constant 1 while data_req high, else 0
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  32  st_addr unmodified
- data_wdata  out  32  lane-replicated data
- data_wstrb  out  4  byte enables
- data_addr_ok  in  1  bus accepted request this cycle
- data_data_ok  in  1  bus completed write this cycle

## Operation
- States: IDLE, REQ, WAIT. Bus output fields registered at acceptance; stable while data_req high.
- Encoding: SB wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011; SW wdata=d, wstrb=1111.
- Alignment: SH with addr[0]=1, or SW with addr[1:0]!=0 -> no bus request; stay IDLE; st_ades pulses next cycle, st_badvaddr<=st_addr.
- IDLE->REQ on aligned acceptance. REQ: data_req=1; on data_addr_ok -> WAIT. WAIT: data_req=0; on data_data_ok -> IDLE, st_done pulse unless cancelled.
- data_data_ok in IDLE/REQ ignored; data_addr_ok outside REQ ignored.
- flush and st_valid same cycle: not accepted, no ades.
- flush in REQ without data_addr_ok same cycle: data_req drops next cycle, -> IDLE, no done.
- flush in REQ with data_addr_ok same cycle: handshake completed; -> WAIT with cancel flag set; drain data_ok, suppress st_done.
- flush in WAIT: set cancel flag, keep waiting for data_ok, suppress st_done. Cancel flag cleared on return to IDLE.
- flush in IDLE: no effect (pending st_ades pulse still fires).

## Timing
- Reset (resetn low, async): state IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0, st_done=0, st_ades=0, st_badvaddr=0, cancel=0. st_ready reads 1 but st_valid ignored while resetn low.
- Accept in cycle T -> data_req high T+1. addr_ok at T+k -> data_req low T+k+1. data_ok at T+m -> st_done and st_ready high T+m+1.
- Minimum: accept T, addr_ok T+1, data_ok T+2, st_done T+3; next store may be accepted at T+3 (back-to-back).
- Misaligned: accept T, st_ades T+1, st_ready stays high (new request acceptable T+1).
- Reset mid-transaction: outputs return to reset values immediately; no completion reported.

## Test plan
- SB addr 0x1003 data 0x000000A5 -> data_size=0, wstrb=1000, wdata=0xA5A5A5A5; addr_ok T+1, data_ok T+2 -> st_done at T+3 only.
- SH addr 0x2002 data 0x1234BEEF -> wstrb=1100, wdata=0xBEEFBEEF; SW 0x3000 -> wstrb=1111; addr_ok delayed 3 cycles -> req and fields held stable throughout.
- SW addr 0x4006 -> no data_req, st_ades T+1, st_badvaddr=0x4006; SH 0x4001 -> same with 0x4001.
- flush in REQ before addr_ok -> data_req drops next cycle, no st_done; flush same cycle as addr_ok -> WAIT, data_ok drained, no st_done, st_ready returns after data_ok.
- Back-to-back SB/SH/SW with zero-wait bus -> three st_done pulses 3 cycles apart, no lost/duplicated requests; spurious data_ok in IDLE ignored.
- resetn pulsed low while in WAIT -> all outputs to reset values immediately, st_done never pulses.
